// File: rtl/sort_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sort_serializer
// Purpose  : Captures five unsigned elements on a start request and sorts
//            them ascending with a bubble sort. Each cycle compares one
//            adjacent pair, and the sort exits early after a pass with no
//            swaps. The sorted elements are then streamed out one per
//            valid/ready handshake, and done pulses after the last one.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   load-and-sort request, honoured only while idle
//   in1..in5   in   WIDTH-bit unsigned elements captured with start
//   busy       out  high while sorting or streaming
//   out_data   out  current element of the sorted stream (0 when not valid)
//   out_valid  out  out_data holds a valid element
//   out_ready  in   consumer accepts out_data on this edge
//   out_last   out  qualifies the fifth (largest) element
//   done       out  one-cycle pulse after the final transfer
// ============================================================================
module sort_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  output logic             busy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done
);

  localparam logic [1:0] c_LAST_PAIR = 2'd3;   // pair (3,4) closes a pass
  localparam logic [2:0] c_LAST_PASS = 3'd3;   // pass index 3 is the fourth pass
  localparam logic [2:0] c_LAST_ELEM = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_elem [0:4];
  logic [1:0]       r_j;          // pair index within the current pass
  logic [2:0]       r_p;          // completed passes
  logic             r_swapped;    // a swap happened earlier in this pass
  logic [2:0]       r_k;          // element index while streaming
  logic             r_done;

  logic [2:0]       w_lo_idx;
  logic [2:0]       w_hi_idx;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic             w_do_swap;
  logic             w_pass_end;
  logic             w_pass_swapped;
  logic             w_sort_done;
  logic             w_last;
  logic [WIDTH-1:0] w_cur;

  assign w_lo_idx       = {1'b0, r_j};
  assign w_hi_idx       = {1'b0, r_j} + 3'd1;
  assign w_lo           = r_elem[w_lo_idx];
  assign w_hi           = r_elem[w_hi_idx];
  // Strict compare keeps equal elements in place.
  assign w_do_swap      = (r_state == ST_SORT) && (w_lo > w_hi);
  assign w_pass_end     = (r_j == c_LAST_PAIR);
  // Include a swap made on the closing pair when judging the pass.
  assign w_pass_swapped = r_swapped | w_do_swap;
  // Four passes always suffice for five elements, so stop there regardless.
  assign w_sort_done    = w_pass_end && (!w_pass_swapped || (r_p == c_LAST_PASS));
  assign w_last         = (r_k == c_LAST_ELEM);

  always_comb begin
    w_cur = '0;
    case (r_k)
      3'd0:    w_cur = r_elem[0];
      3'd1:    w_cur = r_elem[1];
      3'd2:    w_cur = r_elem[2];
      3'd3:    w_cur = r_elem[3];
      3'd4:    w_cur = r_elem[4];
      default: w_cur = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_SORT;
        end
      end
      ST_SORT: begin
        busy = 1'b1;
        if (w_sort_done) begin
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = w_last;
        out_data  = w_cur;
        if (out_ready && w_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: element storage, sort indices, stream index, done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        r_elem[i] <= '0;
      end
      r_j       <= '0;
      r_p       <= '0;
      r_swapped <= 1'b0;
      r_k       <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_elem[0] <= in1;
            r_elem[1] <= in2;
            r_elem[2] <= in3;
            r_elem[3] <= in4;
            r_elem[4] <= in5;
            r_j       <= '0;
            r_p       <= '0;
            r_swapped <= 1'b0;
            r_k       <= '0;
          end
        end
        ST_SORT: begin
          if (w_do_swap) begin
            r_elem[w_lo_idx] <= w_hi;
            r_elem[w_hi_idx] <= w_lo;
          end
          if (w_pass_end) begin
            r_p       <= r_p + 3'd1;
            r_j       <= '0;
            r_swapped <= 1'b0;
            if (w_sort_done) begin
              r_k <= '0;
            end
          end else begin
            r_j       <= r_j + 2'd1;
            r_swapped <= w_pass_swapped;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (w_last) begin
              r_k    <= '0;
              r_done <= 1'b1;
            end else begin
              r_k <= r_k + 3'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sort_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_serializer
// Purpose  : Self-checking bench for sort_serializer. A reference model
//            predicts the sorted stream (plain sort) and the SORT latency
//            (pass count derived from the largest number of greater elements
//            preceding any element), and checks the handshake behaviour.
// Revision : 1.0  initial release
// ============================================================================
module tb_sort_serializer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] in1, in2, in3, in4, in5;
  logic             busy;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             done;

  int n_cmp  = 0;
  int n_fail = 0;

  sort_serializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .in5       (in5),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: ascending order of the five values.
  task automatic ref_sort(input int v[5], output int s[5]);
    int t;
    s = v;
    for (int a = 0; a < 5; a++) begin
      for (int b = a + 1; b < 5; b++) begin
        if (s[b] < s[a]) begin
          t = s[a]; s[a] = s[b]; s[b] = t;
        end
      end
    end
  endtask

  // Bubble sort needs (max count of larger predecessors) swapping passes plus
  // one clean pass to notice it is finished, capped at four passes.
  function automatic int ref_passes(input int v[5]);
    int m = 0;
    int c;
    for (int i = 0; i < 5; i++) begin
      c = 0;
      for (int j = 0; j < i; j++) begin
        if (v[j] > v[i]) c++;
      end
      if (c > m) m = c;
    end
    return (m + 1 > 4) ? 4 : m + 1;
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 3) == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Load five values, then check SORT latency and the whole output stream.
  // mode: 0 always ready, 1 ready 1,0,0 repeating, 2 random ready.
  // poke: re-pulse start with fresh inputs during SORT and SEND.
  task automatic run_case(input string name, input int v0, input int v1, input int v2,
                          input int v3, input int v4, input int mode, input bit poke);
    int v[5];
    int s[5];
    int n;
    int idx;
    int cyc;
    logic rdy;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3; v[4] = v4;
    ref_sort(v, s);
    in1 = v0[7:0]; in2 = v1[7:0]; in3 = v2[7:0]; in4 = v3[7:0]; in5 = v4[7:0];
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, " busy_in_sort"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 40) begin
      if (poke && n == 1) begin
        start = 1'b1;
        in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom);
        in4 = 8'($urandom); in5 = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done !== 1'b0) check({name, " done_during_sort"}, 32'(done), 32'd0);
      tick();
      n++;
    end
    start = 1'b0;
    check({name, " sort_cycles"}, n, 4 * ref_passes(v));
    idx = 0;
    cyc = 0;
    while (idx < 5 && cyc < 60) begin
      rdy = ready_for(mode, cyc);
      out_ready = rdy;
      start = (poke && cyc == 0) ? 1'b1 : 1'b0;
      if (poke && cyc == 0) begin
        in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom);
        in4 = 8'($urandom); in5 = 8'($urandom);
      end
      check($sformatf("%s valid[%0d]", name, idx), 32'(out_valid), 32'd1);
      check($sformatf("%s data[%0d]", name, idx), 32'(out_data), s[idx]);
      check($sformatf("%s last[%0d]", name, idx), 32'(out_last), (idx == 4) ? 32'd1 : 32'd0);
      check($sformatf("%s no_early_done[%0d]", name, idx), 32'(done), 32'd0);
      tick();
      cyc++;
      if (rdy) idx++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check({name, " transfers"}, idx, 5);
    check({name, " done_pulse"}, 32'(done), 32'd1);
    check({name, " valid_dropped"}, 32'(out_valid), 32'd0);
    check({name, " idle_busy"}, 32'(busy), 32'd0);
    tick();
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
    check({name, " stays_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b1;        // reset must win over start and out_ready
    out_ready = 1'b1;
    in1 = 8'd7; in2 = 8'd6; in3 = 8'd5; in4 = 8'd4; in5 = 8'd3;
    tick();
    tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst last", 32'(out_last), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst data", 32'(out_data), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    run_case("four_pass", 16, 14, 15, 17, 12, 0, 1'b0);
    run_case("sorted", 1, 2, 3, 4, 5, 0, 1'b0);
    run_case("dups_stall", 9, 9, 3, 9, 3, 1, 1'b0);
    run_case("extremes", 255, 0, 128, 0, 255, 0, 1'b0);
    run_case("poke", 40, 10, 30, 20, 50, 0, 1'b1);

    // Reset in the middle of SEND after two transfers.
    in1 = 8'd8; in2 = 8'd3; in3 = 8'd6; in4 = 8'd1; in5 = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("mid_rst reached_send", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    tick();
    check("mid_rst still_sending", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    check("mid_rst valid", 32'(out_valid), 32'd0);
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst done", 32'(done), 32'd0);
    check("mid_rst data", 32'(out_data), 32'd0);
    start = 1'b0;
    out_ready = 1'b0;
    tick();
    check("mid_rst no_done_later", 32'(done), 32'd0);
    rst_n = 1'b1;
    // Start is presented on the very first edge with reset released.
    run_case("after_rst", 5, 4, 3, 2, 1, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      run_case($sformatf("rand%0d", t),
               (t < 4) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)),
               (t < 4) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)),
               (t < 4) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)),
               (t < 4) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)),
               (t < 4) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)),
               t % 3, 1'(t % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
